multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM for the multicycle RV32I datapath: one shared ALU, a unified instruction/data memory port, and IR/OldPC/ALUOut/Data holding registers. It decodes `op`/`funct3`/`funct7b5` and steps each instruction through fetch, decode, execute, memory and writeback states, driving every mux select and write enable. It sits beside the datapath in the multicycle top and stalls on a memory-ready handshake.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `op` in 7: instruction opcode from IR.
- `funct3` in 3: IR[14:12].
- `funct7b5` in 1: IR[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select, 0=PC, 1=ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: IR and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 2: 00=PC, 01=OldPC, 10=RD1.
- `ALUSrcB` out 2: 00=RD2, 01=ImmExt, 10=constant 4.
- `ImmSrc` out 2: 00=I, 01=S, 10=B, 11=J.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Encodings 11–15 are unreachable and transition to FETCH.
- Outputs not listed for a state are 0. `ALUOp` is internal: 00=add, 01=sub, 10=funct.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, computing the branch target into ALUOut. Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH with illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held until the cycle mem_ready=1, then → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB, which writes PC+4 to rd.
- ImmSrc is combinational from `op` in every state: lw/I-ALU=00, sw=01, beq=10, jal=11, others=00.
- ALU decode:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 by funct3: 000 gives sub if op[5]&funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add.
  - ALUOp 11 is unused and decodes to add.

## Timing
- The state register updates on the rising edge of clk. All outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready. There are no registered outputs.
- Reset:
  - The state register loads FETCH when reset_n=0 at a rising edge.
  - While reset_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0, and illegal is forced to 0.
  - A reset mid-instruction abandons it, and no further writes occur.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No enables other than the held MemWrite are asserted during a stall.
- illegal is high only in DECODE with an unsupported op, and lasts exactly one cycle.
- BEQ samples zero in the same cycle; a not-taken branch asserts no PCWrite, because PC already holds PC+4 from FETCH.

## Test plan
- Reset: hold reset_n=0 for 3 cycles in an arbitrary state → state=0, all write enables 0. Release → FETCH issues IRWrite=PCWrite=1 on the first cycle with mem_ready=1.
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0) with mem_ready=1 → states 0,1,6,8,0. ALUControl=000 in EXECR; RegWrite=1 only in ALUWB. Repeat with f7b5=1 → ALUControl=001.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → states 0,0,0,1,2,3,3,3,3,4,0. IRWrite pulses once and RegWrite pulses once.
- beq with zero=1, then with zero=0 → states 0,1,9,0. PCWrite=1 in BEQ only when zero=1; ALUControl=001 in BEQ.
- jal → states 0,1,10,8,0 with ImmSrc=11. In JAL: PCWrite=1, ALUSrcA=01, ALUSrcB=10. In ALUWB: RegWrite=1.
- Unsupported op 1111111 → states 0,1,0, with illegal=1 only in the DECODE cycle. Also check sw: MemWrite is held across a 2-cycle mem_ready stall, then the FSM returns to FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and enable.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                illegal = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
                            op == OP_BEQ || op == OP_JAL);
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any in-flight instruction: no architectural writes while held.
        if (!reset_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign state = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence and checks selects, enables and stall behaviour cycle by cycle.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] wr;
        reset_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_init_state got=%0d exp=0", state); end
        tick();
        // Now in DECODE; reassert reset with an illegal opcode present.
        op = 7'b1111111; reset_n = 1'b0;
        #1;
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal_forced got=%b exp=0", illegal); end
        for (int i = 0; i < 3; i++) begin
            tick();
            wr = {PCWrite, IRWrite, MemWrite, RegWrite};
            checks++;
            if (state !== 4'd0 || wr !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d state=%0d en=%b exp state=0 en=0000", i, state, wr);
            end
        end
        reset_n = 1'b1; op = 7'b1111111; mem_ready = 1'b0;
        #1;
        checks++;
        if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
            errors++; $display("FAIL reset_release_stall ir=%b pc=%b exp 0 0", IRWrite, PCWrite);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
            errors++; $display("FAIL reset_release_fetch ir=%b pc=%b exp 1 1", IRWrite, PCWrite);
        end
        tick(); tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_back_to_fetch got=%0d exp=0", state); end
    endtask

    task automatic test_rtype(input logic f7, input logic [2:0] exp_alu);
        logic [3:0] es [5];
        es = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = f7; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== es[i] || RegWrite !== (i == 3)) begin
                errors++;
                $display("FAIL rtype f7=%b cyc=%0d state=%0d rw=%b exp state=%0d rw=%b",
                         f7, i, state, RegWrite, es[i], (i == 3));
            end
            if (i == 2) begin
                checks++;
                if (ALUControl !== exp_alu || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin
                    errors++;
                    $display("FAIL rtype_alu f7=%b ctl=%b a=%b b=%b exp ctl=%b a=10 b=00",
                             f7, ALUControl, ALUSrcA, ALUSrcB, exp_alu);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_itype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu);
        logic [3:0] es [5];
        es = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        op = 7'b0010011; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== es[i]) begin
                errors++; $display("FAIL itype cyc=%0d state=%0d exp=%0d", i, state, es[i]);
            end
            if (i == 2) begin
                checks++;
                if (ALUControl !== exp_alu || ALUSrcB !== 2'b01 || ImmSrc !== 2'b00) begin
                    errors++;
                    $display("FAIL itype_alu f3=%b ctl=%b b=%b imm=%b exp ctl=%b b=01 imm=00",
                             f3, ALUControl, ALUSrcB, ImmSrc, exp_alu);
                end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0] es [11];
        logic       mr [11];
        int ir_cnt, rw_cnt, mw_cnt;
        es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        ir_cnt = 0; rw_cnt = 0; mw_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== es[i]) begin
                errors++; $display("FAIL lw_seq cyc=%0d state=%0d exp=%0d", i, state, es[i]);
            end
            if (i == 5) begin
                checks++;
                if (AdrSrc !== 1'b1) begin errors++; $display("FAIL lw_adrsrc got=%b exp=1", AdrSrc); end
            end
            if (i == 9) begin
                checks++;
                if (ResultSrc !== 2'b01) begin errors++; $display("FAIL lw_resultsrc got=%b exp=01", ResultSrc); end
            end
            if (i < 10) begin
                ir_cnt += int'(IRWrite);
                rw_cnt += int'(RegWrite);
                mw_cnt += int'(MemWrite) + int'(PCWrite && i != 2);
                tick();
            end
        end
        checks++;
        if (ir_cnt != 1 || rw_cnt != 1 || mw_cnt != 0) begin
            errors++;
            $display("FAIL lw_pulses ir=%0d rw=%0d stray=%0d exp 1 1 0", ir_cnt, rw_cnt, mw_cnt);
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] es [4];
        es = '{4'd0, 4'd1, 4'd9, 4'd0};
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== es[i]) begin
                errors++; $display("FAIL beq z=%b cyc=%0d state=%0d exp=%0d", z, i, state, es[i]);
            end
            if (i == 1) begin
                checks++;
                if (PCWrite !== 1'b0 || ImmSrc !== 2'b10) begin
                    errors++; $display("FAIL beq_decode pc=%b imm=%b exp 0 10", PCWrite, ImmSrc);
                end
            end
            if (i == 2) begin
                checks++;
                if (PCWrite !== z || ALUControl !== 3'b001) begin
                    errors++;
                    $display("FAIL beq_exec z=%b pc=%b ctl=%b exp pc=%b ctl=001", z, PCWrite, ALUControl, z);
                end
            end
            if (i < 3) tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0] es [5];
        es = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== es[i] || ImmSrc !== 2'b11) begin
                errors++;
                $display("FAIL jal cyc=%0d state=%0d imm=%b exp state=%0d imm=11", i, state, ImmSrc, es[i]);
            end
            if (i == 2) begin
                checks++;
                if (PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin
                    errors++;
                    $display("FAIL jal_exec pc=%b a=%b b=%b exp 1 01 10", PCWrite, ALUSrcA, ALUSrcB);
                end
            end
            if (i == 3) begin
                checks++;
                if (RegWrite !== 1'b1) begin errors++; $display("FAIL jal_wb rw=%b exp=1", RegWrite); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] es [3];
        es = '{4'd0, 4'd1, 4'd0};
        op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== es[i] || illegal !== (i == 1)) begin
                errors++;
                $display("FAIL illegal cyc=%0d state=%0d ill=%b exp state=%0d ill=%b",
                         i, state, illegal, es[i], (i == 1));
            end
            if (i < 2) tick();
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0] es [7];
        logic       mr [7];
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            #1;
            checks++;
            if (state !== es[i] || MemWrite !== (i >= 3 && i <= 5)) begin
                errors++;
                $display("FAIL sw cyc=%0d state=%0d mw=%b exp state=%0d mw=%b",
                         i, state, MemWrite, es[i], (i >= 3 && i <= 5));
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (AdrSrc !== 1'b1 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0 ||
                    ImmSrc !== 2'b01) begin
                    errors++;
                    $display("FAIL sw_stall cyc=%0d adr=%b pc=%b ir=%b rw=%b imm=%b exp 1 0 0 0 01",
                             i, AdrSrc, PCWrite, IRWrite, RegWrite, ImmSrc);
                end
            end
            if (i < 6) tick();
        end
    endtask

    initial begin
        test_reset();
        test_rtype(1'b0, 3'b000);
        test_rtype(1'b1, 3'b001);
        test_itype(3'b110, 1'b0, 3'b011);
        test_itype(3'b010, 1'b0, 3'b101);
        test_itype(3'b000, 1'b1, 3'b000);
        test_itype(3'b111, 1'b0, 3'b010);
        test_lw_stall();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_illegal();
        test_sw_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
